// File: rtl/ygr_hirq_ctrl_pkg.sv
// Shared YGR019 host-interface types and constants for the HIRQ request/mask unit.
// Reused as parameter defaults by the controller and its interrupt shaper.
package ygr_hirq_ctrl_pkg;

    typedef enum logic {
        LEVEL = 1'b0,
        PULSE = 1'b1
    } HIRQ_MODE_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } HIRQ_STATE_t;

    localparam logic [15:0] HIRQ_WMASK = 16'h3FFF;
    localparam logic [15:0] HIRQ_INIT  = 16'h0000;
    localparam logic [15:0] HMSK_INIT  = 16'hFFFF;

    function automatic int hirq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ygr_irq_shaper.sv
// Host interrupt line shaper: level/pulse FSM with pulse-width and deassert-holdoff counters.
// Consumes PEND plus rise/clear strobes computed by the register file.
module ygr_irq_shaper
    import ygr_hirq_ctrl_pkg::*;
#(
    parameter HIRQ_MODE_t IRQ_MODE  = LEVEL,
    parameter int         PULSE_LEN = 4,
    parameter int         HOLDOFF   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic pend,
    input  logic pend_nxt,
    input  logic rise,
    input  logic clr,
    output logic irq_n
);

    localparam int CMAX = hirq_max(PULSE_LEN, HOLDOFF);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] P_LD  = CW'(PULSE_LEN);
    localparam logic [CW-1:0] H_LD  = CW'(HOLDOFF);
    localparam logic [CW-1:0] HP_LD = CW'(hirq_max(HOLDOFF, 1));
    localparam logic [CW-1:0] ONE   = CW'(1);

    HIRQ_STATE_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
    logic          late_q, late_d;
    logic          irq_n_q, irq_n_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        late_d  = late_q;
        cnt_dec = (cnt_q == '0) ? '0 : cnt_q - ONE;
        if (ce) begin
            if (IRQ_MODE == LEVEL) begin
                unique case (state_q)
                    IDLE: begin
                        if (pend && cnt_q == '0) state_d = ASSERT;
                    end
                    ASSERT: begin
                        if (clr) begin
                            if (HOLDOFF == 0) begin
                                state_d = IDLE;
                            end else begin
                                state_d = HOLD;
                                cnt_d   = H_LD;
                            end
                        end else if (!pend_nxt) begin
                            state_d = IDLE;
                        end
                    end
                    HOLD: begin
                        if (cnt_q <= ONE) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                // Rises seen mid-pulse or mid-holdoff are remembered, not retriggered
                unique case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_d = ASSERT;
                            cnt_d   = P_LD;
                        end
                    end
                    ASSERT: begin
                        late_d = late_q | rise;
                        if (cnt_q <= ONE) begin
                            state_d = HOLD;
                            cnt_d   = HP_LD;
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                    HOLD: begin
                        if (cnt_q <= ONE) begin
                            late_d = 1'b0;
                            if (late_q | rise) begin
                                state_d = ASSERT;
                                cnt_d   = P_LD;
                            end else begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end
                        end else begin
                            cnt_d  = cnt_dec;
                            late_d = late_q | rise;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        irq_n_d = (state_d != ASSERT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            late_q  <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            late_q  <= late_d;
            irq_n_q <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;

endmodule

// File: rtl/ygr_hirq_ctrl.sv
// Host interrupt request/mask register pair for the CD block host interface.
// Sticky write-0-to-clear requests, writable mask, and the shaped IRQ_N line.
module ygr_hirq_ctrl
    import ygr_hirq_ctrl_pkg::*;
#(
    parameter int          N         = 14,
    parameter logic [15:0] REQ_INIT  = HIRQ_INIT,
    parameter logic [15:0] MSK_INIT  = HMSK_INIT,
    parameter logic [15:0] WMASK     = HIRQ_WMASK,
    parameter int          IRQ_MODE  = 0,
    parameter int          PULSE_LEN = 4,
    parameter int          HOLDOFF   = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CE,
    input  logic          REG_SEL,
    input  logic          WR,
    input  logic          RD,
    input  logic [15:0]   WDATA,
    output logic [15:0]   RDATA,
    input  logic [N-1:0]  EVT_SET,
    output logic [N-1:0]  REQ,
    output logic          PEND,
    output logic          IRQ_N
);

    localparam logic [N-1:0] WM = WMASK[N-1:0];

    logic [N-1:0] req_q, req_d, req_wr;
    logic [N-1:0] msk_q, msk_d;
    logic [15:0]  rdata_q, rdata_d, rd_word;
    logic         wr_req, wr_msk;
    logic         pend_d, clr_stb, rise_stb;
    logic         unused_wdata;

    always_comb begin
        wr_req  = CE & WR & ~REG_SEL;
        wr_msk  = CE & WR & REG_SEL;
        req_wr  = wr_req ? (req_q & (WDATA[N-1:0] | ~WM)) : req_q;
        req_d   = CE ? (req_wr | EVT_SET) : req_q;
        msk_d   = wr_msk ? ((msk_q & ~WM) | (WDATA[N-1:0] & WM)) : msk_q;
        rd_word = '0;
        rd_word[N-1:0] = REG_SEL ? msk_q : req_q;
        rd_word = rd_word & WMASK;
        rdata_d = (CE & RD) ? rd_word : rdata_q;
        pend_d  = |(req_d & msk_d);
        // Only host writes can drop a request bit, so any 1->0 is a clear
        clr_stb  = |(req_q & ~req_d);
        rise_stb = (|(req_d & ~req_q & msk_d)) | (wr_msk & ~PEND & pend_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q   <= REQ_INIT[N-1:0];
            msk_q   <= MSK_INIT[N-1:0];
            rdata_q <= '0;
        end else begin
            req_q   <= req_d;
            msk_q   <= msk_d;
            rdata_q <= rdata_d;
        end
    end

    assign PEND         = |(req_q & msk_q);
    assign REQ          = req_q;
    assign RDATA        = rdata_q;
    assign unused_wdata = ^WDATA;

    ygr_irq_shaper #(
        .IRQ_MODE  ((IRQ_MODE == 0) ? LEVEL : PULSE),
        .PULSE_LEN (PULSE_LEN),
        .HOLDOFF   (HOLDOFF)
    ) u_shaper (
        .clk      (CLK),
        .rst_n    (RST_N),
        .ce       (CE),
        .pend     (PEND),
        .pend_nxt (pend_d),
        .rise     (rise_stb),
        .clr      (clr_stb),
        .irq_n    (IRQ_N)
    );

endmodule

// File: doc/ygr_hirq_ctrl.md
Name: ygr_hirq_ctrl

Overview:
- Parametrised host interrupt request/mask unit for the CD block host interface, the successor to the fixed 14-bit HIRQREQ/HIRQMSK register pair.
- Holds N sticky request flags with write-0-to-clear host semantics and an N-bit mask.
- Drives the active-low host interrupt line in level or pulse mode, with a programmable deassert holdoff.
- Sits between the CD firmware event sources and the host register decoder (258XXX08/0C-style word registers).

Parameters:
N, 14, number of interrupt sources (1..16)
REQ_INIT, 16'h0000, reset value of request flags (low N bits used)
MSK_INIT, 16'hFFFF, reset value of mask (low N bits used)
WMASK, 16'h3FFF, writable-bit mask applied to both registers
IRQ_MODE, 0, 0 = level output, 1 = pulse output
PULSE_LEN, 4, pulse-mode low width in CE cycles (>=1)
HOLDOFF, 2, CE cycles IRQ_N is forced high after a clearing host write (0 = none)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CE  in  1  clock enable; all state advances only when CE=1
REG_SEL  in  1  0 = request register, 1 = mask register
WR  in  1  host write strobe, one CE cycle
RD  in  1  host read strobe, one CE cycle
WDATA  in  16  host write data
RDATA  out  16  host read data, registered
EVT_SET  in  N  firmware event pulses; bit k sets REQ[k]
REQ  out  N  current request flags (firmware view)
PEND  out  1  |(REQ & MSK), combinational
IRQ_N  out  1  host interrupt, active low, registered

Behaviour:
- Reset (async, RST_N=0): REQ=REQ_INIT[N-1:0], MSK=MSK_INIT[N-1:0], RDATA=0, IRQ_N=1, FSM=IDLE, counters=0.
- REQ update per CE cycle: REQ_next = (WR&~REG_SEL ? REQ & (WDATA | ~WMASK) : REQ) | EVT_SET.
  - Set wins over a simultaneous clear on the same bit.
  - Bits outside WMASK are unaffected by writes.
- MSK write: MSK_next = (MSK & ~WMASK) | (WDATA & WMASK), low N bits. Mask writes never change REQ.
- Read: on RD with CE, RDATA <= zero-extended REQ or MSK, masked by WMASK; valid the next CE cycle; held until the next RD.
  - RD and WR together: RDATA returns the pre-write value.
- "Clearing write" = REQ write that changes at least one REQ bit from 1 to 0 (after set-wins resolution).
- FSM states: IDLE, ASSERT, HOLD. IRQ_N=0 only in ASSERT.
  - IDLE -> ASSERT: when PEND=1 and the holdoff counter is 0.
  - Level mode, ASSERT -> HOLD: on a clearing write. HOLD loads HOLDOFF; if HOLDOFF=0, go directly to IDLE.
  - Level mode, ASSERT -> IDLE: when PEND drops because of a mask write with no clear.
  - Pulse mode, IDLE -> ASSERT: only on a new masked rise, i.e. bit k with (REQ_next & ~REQ & MSK_next)[k]=1, or PEND going 0 -> 1 via a mask write.
  - Pulse mode, ASSERT: width counter runs PULSE_LEN cycles, then -> HOLD(max(HOLDOFF,1)). New rises during ASSERT are not retriggered.
  - Pulse mode, HOLD: a rise seen during HOLD is latched and fires a new pulse on exit from HOLD.
  - HOLD -> IDLE: when the counter reaches 0. In level mode, IDLE re-asserts next cycle if PEND is still 1.
- IRQ_N is registered: one CE cycle from the qualifying event to IRQ_N falling.
- CE=0: all registers hold, counters freeze, strobes are ignored.
- Reset mid-pulse or mid-holdoff: immediate return to the reset state; IRQ_N=1 asynchronously.
- Counter widths: $clog2(max(PULSE_LEN,HOLDOFF)+1). Counters must not wrap: they saturate at 0.

Decomposition:
- Extend the shared YGR019 package with:
  - typedef HIRQ_MODE_t (enum LEVEL, PULSE)
  - typedef HIRQ_STATE_t (IDLE, ASSERT, HOLD)
  - HIRQ_WMASK/HIRQ_INIT/HMSK_INIT constants reused as parameter defaults
- One natural sub-module: ygr_irq_shaper (FSM + width/holdoff counters), taking PEND and the rise/clear strobes and producing IRQ_N. The register file stays in the top.

Test Plan:
- Reset defaults: RST_N low mid-run -> IRQ_N=1 immediately; RD REQ -> 0x0000; RD MSK -> 0x3FFF.
- Level mode, EVT_SET=0x0001 -> IRQ_N low one cycle later. Host writes REQ=0xFFFE -> REQ=0, IRQ_N high for HOLDOFF=2 cycles, then stays high.
- Set beats clear: EVT_SET[3] in the same cycle as a REQ write of 0xFFF7 -> REQ[3]=1, PEND=1, no HOLD entry.
- Masking: MSK=0x0000, EVT_SET=0x0010 -> REQ=0x0010, IRQ_N=1. Write MSK=0x0010 -> IRQ_N=0 next cycle.
- Pulse mode (PULSE_LEN=4): EVT_SET[1] -> IRQ_N low exactly 4 cycles; EVT_SET[2] arriving during the pulse -> a second 4-cycle pulse after HOLD ends; no third pulse.
- CE gating: CE toggled 1/0 -> pulse width and holdoff measured in CE cycles only; WR with CE=0 leaves REQ unchanged.
